bounce_gen: RTL
===============

# bounce_gen

Synthesizable contact-bounce emulator: drives a pin-level output that chatters pseudo-randomly for a bounded time after each change of a clean commanded level, then settles to that level. It sits on the stimulus side of the debounce path. On-board self-test and loop-back benches use it to exercise button/switch debouncers with repeatable, seed-controlled bounce patterns.

## Interface
Parameters:
- INIT_LEVEL, 1'b0, level of `signal_o` and `target_q` after reset
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001
- WAIT_BITS, 10, width of the random inter-edge gap; gap D = 1 + lfsr[WAIT_BITS-1:0], range 1..2^WAIT_BITS cycles; legal range 1..16
- CNT_BITS, 3, width of the random extra-toggle count; K = lfsr[15 -: CNT_BITS], range 0..2^CNT_BITS-1; legal range 1..8

Ports:
- clk, input, 1, single clock, all logic on posedge
- rst, input, 1, asynchronous, active-high reset
- level_i, input, 1, clean commanded level, synchronous to clk
- bounce_en, input, 1, 1 = emulate bounce, 0 = clean step; sampled only in IDLE
- signal_o, output, 1, emulated contact output (registered)
- busy_o, output, 1, high while in BOUNCE (registered)
- done_o, output, 1, one-cycle pulse when `signal_o` takes its settled value (registered)

## Operation
- State: IDLE, BOUNCE. Registers: `target_q` (last commanded level), `toggles_left` (CNT_BITS), `wait_cnt` (WAIT_BITS+1), `lfsr` (16).
- LFSR: 16-bit Galois, right shift, feedback mask 16'hB400. It advances every cycle in every state. D and K are taken from the pre-advance value in the cycle they are loaded.
- IDLE, with level_i == target_q: hold all outputs; done_o = 0.
- IDLE, level_i != target_q, bounce_en = 0: signal_o <= level_i, target_q <= level_i, done_o <= 1; stay in IDLE.
- IDLE, level_i != target_q, bounce_en = 1:
  - target_q <= level_i; signal_o <= level_i (first edge)
  - toggles_left <= K; wait_cnt <= D
  - busy_o <= 1; go to BOUNCE
- BOUNCE: wait_cnt decrements by 1 per cycle. On the cycle wait_cnt == 1:
  - if toggles_left != 0: signal_o <= ~signal_o, toggles_left <= toggles_left − 1, wait_cnt <= new D
  - else: signal_o <= target_q, done_o <= 1, busy_o <= 0; go to IDLE. This final assignment is an edge only when K is odd.
- level_i and bounce_en are ignored in BOUNCE. A level change during a burst is compared against target_q on the first IDLE cycle. A return to the old level therefore starts a new burst, and a double change does nothing.
- Total edges per bounced step: K+1 when K is even, K+2 when K is odd. The final level always equals the target.
- Reset (any time, including mid-burst): state IDLE, signal_o = target_q = INIT_LEVEL, busy_o = 0, done_o = 0, toggles_left = 0, wait_cnt = 0, lfsr = SEED (or 1).

## Timing
- Commanded change at posedge t (level_i sampled ≠ target_q): signal_o changes at t, and busy_o rises at t (bounce) or done_o pulses at t (clean).
- Burst length = Σ of (K+1) gaps, each 1..2^WAIT_BITS cycles. It is bounded by 2^CNT_BITS · 2^WAIT_BITS cycles.
- done_o is high for exactly one cycle, the cycle after the final assignment edge. busy_o falls on that same edge.
- Minimum spacing between emulated edges: 1 cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset with INIT_LEVEL=0, SEED=16'hACE1 → signal_o=0, busy_o=0, done_o=0. lfsr steps match a Galois 0xB400 model for 100 cycles.
- bounce_en=0, level_i 0→1 → signal_o=1 on the next posedge, done_o high for exactly 1 cycle, busy_o stays 0.
- bounce_en=1, WAIT_BITS=4, CNT_BITS=3, level_i 0→1 → edge count and gap lengths equal the model's K/D draws. Every gap is 1..16 cycles, the final signal_o=1, and done_o pulses once.
- level_i toggles 1→0→1 mid-burst → no extra activity. After done_o, one new burst starts only if level_i ≠ target_q.
- rst asserted mid-burst (asynchronous, between clock edges) → signal_o=INIT_LEVEL and busy_o=0 immediately. After release, the same stimulus reproduces the identical pattern.
- SEED=0 → behaves as SEED=16'h0001; the LFSR never locks at 0 over 70000 cycles.

Source files
------------

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: after each change of the commanded level the output chatters
// pseudo-randomly (seeded 16-bit Galois LFSR) for a bounded time, then settles on the target.
module bounce_gen #(
  parameter logic        INIT_LEVEL = 1'b0,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned WAIT_BITS  = 10,
  parameter int unsigned CNT_BITS   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  input  logic bounce_en,
  output logic signal_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_BOUNCE = 1'b1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  // An all-zero seed would lock the LFSR.
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [WAIT_BITS:0]  WAIT_ONE = (WAIT_BITS + 1)'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  logic [0:0]          r_state;
  logic                r_target;
  logic                r_signal;
  logic                r_busy;
  logic                r_done;
  logic [CNT_BITS-1:0] r_toggles;
  logic [WAIT_BITS:0]  r_wait;
  logic [15:0]         r_lfsr;

  logic [0:0]          w_state_nxt;
  logic                w_target_nxt;
  logic                w_signal_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [CNT_BITS-1:0] w_toggles_nxt;
  logic [WAIT_BITS:0]  w_wait_nxt;
  logic [15:0]         w_lfsr_nxt;
  logic [WAIT_BITS:0]  w_gap;
  logic [CNT_BITS-1:0] w_kick;

  // Draws use the pre-advance LFSR value of the cycle they are loaded in.
  assign w_gap      = {1'b0, r_lfsr[WAIT_BITS-1:0]} + WAIT_ONE;
  assign w_kick     = r_lfsr[15 -: CNT_BITS];
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

  always_comb begin
    w_state_nxt   = r_state;
    w_target_nxt  = r_target;
    w_signal_nxt  = r_signal;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_toggles_nxt = r_toggles;
    w_wait_nxt    = r_wait;
    case (r_state)
      ST_IDLE: begin
        if (level_i != r_target) begin
          w_target_nxt = level_i;
          w_signal_nxt = level_i;
          if (bounce_en) begin
            w_toggles_nxt = w_kick;
            w_wait_nxt    = w_gap;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = ST_BOUNCE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_BOUNCE: begin
        if (r_wait == WAIT_ONE) begin
          if (r_toggles != '0) begin
            w_signal_nxt  = ~r_signal;
            w_toggles_nxt = r_toggles - CNT_ONE;
            w_wait_nxt    = w_gap;
          end else begin
            // Settling assignment; only an edge when the toggle count was odd.
            w_signal_nxt = r_target;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_wait_nxt   = '0;
            w_state_nxt  = ST_IDLE;
          end
        end else begin
          w_wait_nxt = r_wait - WAIT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_target  <= INIT_LEVEL;
      r_signal  <= INIT_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_toggles <= '0;
      r_wait    <= '0;
      r_lfsr    <= LFSR_INIT;
    end else begin
      r_state   <= w_state_nxt;
      r_target  <= w_target_nxt;
      r_signal  <= w_signal_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_toggles <= w_toggles_nxt;
      r_wait    <= w_wait_nxt;
      r_lfsr    <= w_lfsr_nxt;
    end
  end

  assign signal_o = r_signal;
  assign busy_o   = r_busy;
  assign done_o   = r_done;

endmodule
